// File: rtl/clk_div_pkg.sv
// Shared constants and divisor clamp helper for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF       = 26;
  localparam int unsigned DEFAULT_DIV_DEF = 50000;
  localparam int unsigned MIN_DIV         = 2;

  // Divisors below MIN_DIV cannot produce a tick/square-wave pair, so raise them.
  function automatic logic [31:0] clamp_div(input logic [31:0] val);
    return (val < 32'(MIN_DIV)) ? 32'(MIN_DIV) : val;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, shadow divisor, tick strobe and square wave.
// Phase-align input exists only with CLK_DIV_PHASE_ALIGN_EN.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic             i_sync,
`endif
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_tick,
  output logic             o_clk_div
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_act;
  logic [CNT_W-1:0] r_div_pend;
  logic             r_pend_v;
  logic             w_wrap;
  logic             w_sync;
  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] w_half_m1;

`ifdef CLK_DIV_PHASE_ALIGN_EN
  assign w_sync = i_sync;
`else
  assign w_sync = 1'b0;
`endif

  assign w_last    = r_div_act - CNT_W'(1);
  assign w_half_m1 = (r_div_act >> 1) - CNT_W'(1);
  assign w_wrap    = i_en && (r_cnt == w_last);

  // Divisor only changes at a period boundary, so no runt pulses appear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_div_act  <= CNT_W'(DEFAULT_DIV);
      r_div_pend <= '0;
      r_pend_v   <= 1'b0;
      o_tick     <= 1'b0;
      o_clk_div  <= 1'b0;
    end else begin
      o_tick <= w_wrap || w_sync;
      if (w_wrap || w_sync) begin
        r_cnt     <= '0;
        o_clk_div <= 1'b1;
        if (r_pend_v) begin
          r_div_act <= r_div_pend;
          r_pend_v  <= 1'b0;
        end
      end else if (i_en) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == w_half_m1) begin
          o_clk_div <= 1'b0;
        end
      end
      // A write landing on a wrap stays pending for the following wrap.
      if (i_wr) begin
        r_div_pend <= i_div;
        r_pend_v   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: write decode, ack and channel array.
// Optional phase-align strobe enabled by CLK_DIV_PHASE_ALIGN_EN.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH        = 3,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic              i_sync,
`endif
  input  logic [N_CH-1:0]   i_en,
  input  logic              i_div_wr,
  input  logic [CH_W-1:0]   i_div_ch,
  input  logic [CNT_W-1:0]  i_div_val,
  output logic              o_div_ack,
  output logic [N_CH-1:0]   o_tick,
  output logic [N_CH-1:0]   o_clk_div
);

  logic             w_wr_hit;
  logic [CNT_W-1:0] w_div_clamped;

  assign w_wr_hit      = i_div_wr && (32'(i_div_ch) < N_CH);
  assign w_div_clamped = CNT_W'(clamp_div(32'(i_div_val)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_div_ack <= 1'b0;
    end else begin
      o_div_ack <= w_wr_hit;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
`ifdef CLK_DIV_PHASE_ALIGN_EN
      .i_sync    (i_sync),
`endif
      .i_en      (i_en[g]),
      .i_wr      (w_wr_hit && (i_div_ch == CH_W'(g))),
      .i_div     (w_div_clamped),
      .o_tick    (o_tick[g]),
      .o_clk_div (o_clk_div[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: directed segments, each started from reset.
module tb_clk_div_multi;

  localparam int unsigned N_CH  = 3;
  localparam int unsigned CNT_W = 26;
  localparam int unsigned CH_W  = 2;
  localparam int          MAXC  = 64;

  typedef struct {
    int            cyc;
    logic [N_CH-1:0] tick;
    logic          ack;
  } ev_t;

  typedef struct {
    int            cyc;
    logic [N_CH-1:0] mask;
    logic [N_CH-1:0] val;
  } snap_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sync = 1'b0;
  logic [N_CH-1:0]   en = '1;
  logic              div_wr = 1'b0;
  logic [CH_W-1:0]   div_ch = '0;
  logic [CNT_W-1:0]  div_val = '0;
  logic              div_ack;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   clk_div;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  ev_t   eq[$];
  snap_t sq[$];
  logic [N_CH-1:0] et [0:MAXC-1];
  logic            ea [0:MAXC-1];

  clk_div_multi #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
`ifdef CLK_DIV_PHASE_ALIGN_EN
    .i_sync    (sync),
`endif
    .i_en      (en),
    .i_div_wr  (div_wr),
    .i_div_ch  (div_ch),
    .i_div_val (div_val),
    .o_div_ack (div_ack),
    .o_tick    (tick),
    .o_clk_div (clk_div)
  );

  always #5 clk = ~clk;

  // Cycle number = posedges since reset release.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop an expected event whenever the DUT strobes tick or ack.
  always @(negedge clk) begin
    if (!rst) begin
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        snap_t s;
        s = sq.pop_front();
        chk($sformatf("clk_div@%0d", s.cyc), 64'(clk_div & s.mask), 64'(s.val));
      end
      if (tick != '0 || div_ack) begin
        if (eq.size() == 0) begin
          chk("unexpected_strobe", 64'({tick, div_ack}), 64'(0));
        end else begin
          ev_t e;
          e = eq.pop_front();
          chk($sformatf("event@%0d", e.cyc), {32'(cyc), 24'(tick), 8'(div_ack)},
              {32'(e.cyc), 24'(e.tick), 8'(e.ack)});
        end
      end else if (eq.size() > 0 && eq[0].cyc <= cyc) begin
        ev_t e;
        e = eq.pop_front();
        chk($sformatf("missing_event@%0d", e.cyc), {24'(tick), 8'(div_ack)},
            {24'(e.tick), 8'(e.ack)});
      end
    end
  end

  task automatic clear_tbl();
    for (int c = 0; c < MAXC; c++) begin
      et[c] = '0;
      ea[c] = 1'b0;
    end
  endtask

  task automatic add_ticks(input int ch, input int first, input int per, input int last);
    for (int c = first; c <= last; c += per) et[c][ch] = 1'b1;
  endtask

  task automatic add_snap(input int c, input logic [N_CH-1:0] m, input logic [N_CH-1:0] v);
    sq.push_back('{c, m, v});
  endtask

  task automatic flush_tbl();
    for (int c = 0; c < MAXC; c++)
      if (et[c] != '0 || ea[c]) eq.push_back('{c, et[c], ea[c]});
  endtask

  // Reset, check reset outputs, then release with the expected table loaded.
  task automatic seg_start();
    rst = 1'b1;
    div_wr = 1'b0;
    sync = 1'b0;
    en = '1;
    @(negedge clk);
    chk("reset_outputs", 64'({tick, clk_div, div_ack}), 64'(0));
    flush_tbl();
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("reach_cycle_%0d", n), 64'(cyc), 64'(n));
  endtask

  task automatic seg_end(input int n);
    wait_cyc(n);
    #1;
    chk("events_left", 64'(eq.size()), 64'(0));
    chk("snaps_left", 64'(sq.size()), 64'(0));
    eq.delete();
    sq.delete();
    clear_tbl();
  endtask

  task automatic wr(input int ch, input int val);
    div_wr  = 1'b1;
    div_ch  = CH_W'(ch);
    div_val = CNT_W'(val);
    @(negedge clk);
    div_wr  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clear_tbl();
    @(negedge clk);

    // Default divisor 4 on all channels.
    for (int ch = 0; ch < 3; ch++) add_ticks(ch, 4, 4, 20);
    add_snap(2, 3'b111, 3'b000); add_snap(4, 3'b111, 3'b111);
    add_snap(5, 3'b111, 3'b111); add_snap(6, 3'b111, 3'b000);
    add_snap(7, 3'b111, 3'b000); add_snap(8, 3'b111, 3'b111);
    seg_start();
    seg_end(20);

    // Mid-period write of 5 to ch1, then an out-of-range channel write.
    add_ticks(0, 4, 4, 24); add_ticks(2, 4, 4, 24);
    add_ticks(1, 4, 4, 8);  add_ticks(1, 13, 5, 23);
    ea[6] = 1'b1;
    add_snap(9, 3'b010, 3'b010);  add_snap(10, 3'b010, 3'b000);
    add_snap(12, 3'b010, 3'b000); add_snap(13, 3'b010, 3'b010);
    seg_start();
    wait_cyc(5);  wr(1, 5);
    wait_cyc(14); wr(3, 2);
    seg_end(24);

    // Clamp of 0 and 1 to divisor 2.
    add_ticks(0, 4, 2, 16); add_ticks(2, 4, 2, 16); add_ticks(1, 4, 4, 16);
    ea[2] = 1'b1; ea[3] = 1'b1;
    add_snap(4, 3'b101, 3'b101); add_snap(5, 3'b101, 3'b000);
    add_snap(6, 3'b101, 3'b101); add_snap(7, 3'b101, 3'b000);
    seg_start();
    wait_cyc(1); wr(0, 0); wr(2, 1);
    seg_end(16);

    // Back-to-back writes to ch0 (last wins) and write coinciding with ch2 wrap.
    add_ticks(0, 4, 7, 25); add_ticks(1, 4, 4, 28);
    add_ticks(2, 4, 4, 12); add_ticks(2, 15, 3, 27);
    ea[2] = 1'b1; ea[3] = 1'b1; ea[8] = 1'b1;
    add_snap(13, 3'b001, 3'b001); add_snap(14, 3'b001, 3'b000);
    add_snap(17, 3'b001, 3'b000); add_snap(18, 3'b001, 3'b001);
    seg_start();
    wait_cyc(1); wr(0, 6); wr(0, 7);
    wait_cyc(7); wr(2, 3);
    seg_end(28);

    // ch2 disabled for 10 cycles, resumes from held count.
    add_ticks(0, 4, 4, 28); add_ticks(1, 4, 4, 28);
    add_ticks(2, 4, 4, 4);  add_ticks(2, 18, 4, 26);
    add_snap(10, 3'b100, 3'b100); add_snap(15, 3'b100, 3'b100);
    add_snap(16, 3'b100, 3'b000); add_snap(18, 3'b100, 3'b100);
    seg_start();
    wait_cyc(5);  en = 3'b011;
    wait_cyc(15); en = 3'b111;
    seg_end(28);

    // Reset while a write is pending discards it.
    ea[3] = 1'b1;
    seg_start();
    wait_cyc(2); wr(0, 9);
    seg_end(3);
    for (int ch = 0; ch < 3; ch++) add_ticks(ch, 4, 4, 12);
    seg_start();
    seg_end(12);

`ifdef CLK_DIV_PHASE_ALIGN_EN
    // Sync aligns every channel and loads pending divisors.
    et[4] = 3'b111; et[8] = 3'b101; et[9] = 3'b010; et[10] = 3'b111;
    add_ticks(0, 13, 3, 19); add_ticks(1, 15, 5, 20); add_ticks(2, 14, 4, 18);
    ea[2] = 1'b1; ea[8] = 1'b1;
    add_snap(10, 3'b111, 3'b111); add_snap(11, 3'b111, 3'b110);
    seg_start();
    wait_cyc(1); wr(1, 5);
    wait_cyc(7); wr(0, 3);
    wait_cyc(9); sync = 1'b1;
    @(negedge clk); sync = 1'b0;
    seg_end(20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
